// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding,
// pipeline-register index names and counter widths.
package hazard_pkg;

  // FSM state encodings
  localparam logic [1:0] ST_RUN_ENC      = 2'd0;
  localparam logic [1:0] ST_REDIR_ENC    = 2'd1;
  localparam logic [1:0] ST_MEM_WAIT_ENC = 2'd2;

  typedef enum logic [1:0] {
    ST_RUN      = ST_RUN_ENC,
    ST_REDIR    = ST_REDIR_ENC,
    ST_MEM_WAIT = ST_MEM_WAIT_ENC
  } state_e;

  // Pipeline register indices
  localparam int IFID  = 0;
  localparam int IDEX  = 1;
  localparam int EXMEM = 2;
  localparam int MEMWB = 3;

  // Architectural register address width and internal counter widths
  localparam int REG_ADDR_W  = 5;
  localparam int WAIT_CNT_W  = 16;
  localparam int REDIR_CNT_W = 4;

  // True when a source operand is actually read and names the given register
  function automatic logic src_match(input logic [REG_ADDR_W-1:0] rs,
                                     input logic [REG_ADDR_W-1:0] rd,
                                     input logic                  used);
    return used && (rs == rd);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_reg;

  // Count increments, stop at the maximum value, clear on reset or request
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      count_reg <= '0;
    end else if (inc_i && (count_reg != '1)) begin
      count_reg <= count_reg + WIDTH'(1);
    end
  end

  assign count_o = count_reg;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory-stall freeze, branch/jump redirect with
// optional extra IF/ID bubbles, load-use interlock, memory timeout detection
// and a saturating count of taken redirects.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int NPREG       = 4,
  parameter int RES_IDX     = EXMEM,
  parameter int MEM_IDX     = MEMWB,
  parameter int REDIR_EXTRA = 1,
  parameter int TIMEOUT     = 255,
  parameter int CNT_W       = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ex_jump_i,
  input  logic [XLEN-1:0]       ex_target_i,
  input  logic                  ex_is_load_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic [1:0]            id_use_i,
  input  logic                  mem_req_i,
  input  logic                  mem_ack_i,
  output logic                  pc_stall_o,
  output logic                  pc_redirect_o,
  output logic [XLEN-1:0]       pc_target_o,
  output logic [NPREG-1:0]      stall_o,
  output logic [NPREG-1:0]      flush_o,
  output logic                  mem_err_o,
  output logic [CNT_W-1:0]      redir_cnt_o
);

  // Elaboration-time parameter sanity checks
  if (!((RES_IDX >= 1) && (RES_IDX < MEM_IDX) && (MEM_IDX < NPREG))) begin : g_bad_idx
    $error("hazard_ctrl: indices must satisfy 1 <= RES_IDX < MEM_IDX < NPREG");
  end
  if ((REDIR_EXTRA < 0) || (REDIR_EXTRA > 15)) begin : g_bad_extra
    $error("hazard_ctrl: REDIR_EXTRA must be in 0..15");
  end
  if ((TIMEOUT < 1) || (TIMEOUT > 65535)) begin : g_bad_timeout
    $error("hazard_ctrl: TIMEOUT must be in 1..65535");
  end

  localparam logic [WAIT_CNT_W:0]    TIMEOUT_L = (WAIT_CNT_W+1)'(TIMEOUT);
  localparam logic [REDIR_CNT_W-1:0] EXTRA_L   = REDIR_CNT_W'(REDIR_EXTRA);
  // The entry cycle (in RUN/REDIR) is the first stalled cycle, so the first
  // MEM_WAIT cycle with the counter at zero is the second stalled cycle.
  localparam logic [WAIT_CNT_W:0]    STALL_OFS = (WAIT_CNT_W+1)'(2);

  // Per-register masks for the redirect flush, the memory hold and the MEM bubble
  logic [NPREG-1:0] res_mask;
  logic [NPREG-1:0] hold_mask;
  logic [NPREG-1:0] memreg_mask;

  for (genvar gi = 0; gi < NPREG; gi++) begin : g_mask
    assign res_mask[gi]    = (gi < RES_IDX);
    assign hold_mask[gi]   = (gi < MEM_IDX);
    assign memreg_mask[gi] = (gi == MEM_IDX);
  end

  state_e                  state_reg;
  logic [WAIT_CNT_W-1:0]   wait_cnt_reg;
  logic [REDIR_CNT_W-1:0]  redir_left_reg;
  logic                    mem_err_reg;

  logic                    in_wait;
  logic                    mem_stall;
  logic                    can_resolve;
  logic                    redirect;
  logic                    load_use;
  logic                    timeout;
  logic [WAIT_CNT_W:0]     stall_num;

  assign in_wait = (state_reg == ST_MEM_WAIT);

  // In MEM_WAIT the request is held, so only the ack matters
  assign mem_stall = !rst_i && (in_wait ? !mem_ack_i : (mem_req_i && !mem_ack_i));

  // EX may act in RUN, or in the MEM_WAIT ack cycle when the pipe is released;
  // in REDIR EX holds a bubble
  assign can_resolve = !rst_i && !mem_stall && (state_reg != ST_REDIR);

  assign redirect = can_resolve && ex_jump_i;

  assign load_use = can_resolve && !ex_jump_i && ex_is_load_i && (ex_rd_i != '0) &&
                    (src_match(id_rs1_i, ex_rd_i, id_use_i[0]) ||
                     src_match(id_rs2_i, ex_rd_i, id_use_i[1]));

  assign stall_num = {1'b0, wait_cnt_reg} + STALL_OFS;
  assign timeout   = in_wait && !mem_ack_i && (stall_num >= TIMEOUT_L);

  // Combinational pipeline control from state and current inputs
  always_comb begin
    pc_stall_o    = 1'b0;
    pc_redirect_o = 1'b0;
    pc_target_o   = '0;
    stall_o       = '0;
    flush_o       = '0;
    if (rst_i) begin
      flush_o = '1;
    end else begin
      // IF/ID keeps draining during the extra post-redirect bubbles
      if (state_reg == ST_REDIR) begin
        flush_o[IFID] = 1'b1;
      end
      if (mem_stall) begin
        pc_stall_o = 1'b1;
        stall_o    = hold_mask;
        flush_o    = flush_o | memreg_mask;
      end else if (redirect) begin
        pc_redirect_o = 1'b1;
        pc_target_o   = ex_target_i;
        flush_o       = flush_o | res_mask;
      end else if (load_use) begin
        pc_stall_o     = 1'b1;
        stall_o[IFID]  = 1'b1;
        flush_o[IDEX]  = 1'b1;
      end
    end
    // A bubble load wins over a hold on the same register
    stall_o = stall_o & ~flush_o;
  end

  // Hazard FSM with inline wait / redirect-bubble counters and the error pulse
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg      <= ST_RUN;
      wait_cnt_reg   <= '0;
      redir_left_reg <= '0;
      mem_err_reg    <= 1'b0;
    end else begin
      mem_err_reg <= 1'b0;
      unique case (state_reg)
        ST_RUN: begin
          if (mem_stall) begin
            state_reg    <= ST_MEM_WAIT;
            wait_cnt_reg <= '0;
          end else if (redirect && (REDIR_EXTRA > 0)) begin
            state_reg      <= ST_REDIR;
            redir_left_reg <= EXTRA_L;
          end
        end
        ST_REDIR: begin
          if (mem_stall) begin
            state_reg    <= ST_MEM_WAIT;
            wait_cnt_reg <= '0;
          end else if (redir_left_reg <= REDIR_CNT_W'(1)) begin
            state_reg <= ST_RUN;
          end else begin
            redir_left_reg <= redir_left_reg - REDIR_CNT_W'(1);
          end
        end
        ST_MEM_WAIT: begin
          if (mem_ack_i) begin
            // Released: a jump waiting in EX is taken in this cycle
            if (redirect && (REDIR_EXTRA > 0)) begin
              state_reg      <= ST_REDIR;
              redir_left_reg <= EXTRA_L;
            end else begin
              state_reg <= ST_RUN;
            end
          end else if (timeout) begin
            mem_err_reg <= 1'b1;
            state_reg   <= ST_RUN;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + WAIT_CNT_W'(1);
          end
        end
        default: begin
          state_reg <= ST_RUN;
        end
      endcase
    end
  end

  assign mem_err_o = mem_err_reg;

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_redir_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (1'b0),
    .inc_i   (redirect),
    .count_o (redir_cnt_o)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a default-parameter instance and a small
// instance (TIMEOUT=4, CNT_W=2) driven by the same stimulus.
module tb_hazard_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        ex_jump_i;
  logic [31:0] ex_target_i;
  logic        ex_is_load_i;
  logic [4:0]  ex_rd_i;
  logic [4:0]  id_rs1_i;
  logic [4:0]  id_rs2_i;
  logic [1:0]  id_use_i;
  logic        mem_req_i;
  logic        mem_ack_i;

  logic        pc_stall_a, pc_redirect_a, mem_err_a;
  logic [31:0] pc_target_a;
  logic [3:0]  stall_a, flush_a;
  logic [15:0] cnt_a;

  logic        pc_stall_s, pc_redirect_s, mem_err_s;
  logic [31:0] pc_target_s;
  logic [3:0]  stall_s, flush_s;
  logic [1:0]  cnt_s;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  hazard_ctrl dut_a (
    .clk_i(clk_i), .rst_i(rst_i),
    .ex_jump_i(ex_jump_i), .ex_target_i(ex_target_i),
    .ex_is_load_i(ex_is_load_i), .ex_rd_i(ex_rd_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_use_i(id_use_i),
    .mem_req_i(mem_req_i), .mem_ack_i(mem_ack_i),
    .pc_stall_o(pc_stall_a), .pc_redirect_o(pc_redirect_a),
    .pc_target_o(pc_target_a), .stall_o(stall_a), .flush_o(flush_a),
    .mem_err_o(mem_err_a), .redir_cnt_o(cnt_a)
  );

  hazard_ctrl #(.TIMEOUT(4), .CNT_W(2)) dut_s (
    .clk_i(clk_i), .rst_i(rst_i),
    .ex_jump_i(ex_jump_i), .ex_target_i(ex_target_i),
    .ex_is_load_i(ex_is_load_i), .ex_rd_i(ex_rd_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_use_i(id_use_i),
    .mem_req_i(mem_req_i), .mem_ack_i(mem_ack_i),
    .pc_stall_o(pc_stall_s), .pc_redirect_o(pc_redirect_s),
    .pc_target_o(pc_target_s), .stall_o(stall_s), .flush_o(flush_s),
    .mem_err_o(mem_err_s), .redir_cnt_o(cnt_s)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Combinational control of both instances against one expectation
  task automatic chk_comb(input string tag, input logic ps, input logic pr,
                          input logic [3:0] st, input logic [3:0] fl);
    chk({tag, "_pc_stall"}, 64'(pc_stall_a), 64'(ps));
    chk({tag, "_redirect"}, 64'(pc_redirect_a), 64'(pr));
    chk({tag, "_stall_a"},  64'(stall_a), 64'(st));
    chk({tag, "_flush_a"},  64'(flush_a), 64'(fl));
    chk({tag, "_stall_s"},  64'(stall_s), 64'(st));
    chk({tag, "_flush_s"},  64'(flush_s), 64'(fl));
  endtask

  task automatic idle();
    ex_jump_i    = 1'b0;
    ex_target_i  = 32'h0;
    ex_is_load_i = 1'b0;
    ex_rd_i      = 5'd0;
    id_rs1_i     = 5'd0;
    id_rs2_i     = 5'd0;
    id_use_i     = 2'b00;
    mem_req_i    = 1'b0;
    mem_ack_i    = 1'b0;
  endtask

  task automatic sample();
    @(negedge clk_i);
  endtask

  task automatic adv();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    // Reset with a live jump on the inputs: outputs must still be forced
    idle();
    rst_i       = 1'b1;
    ex_jump_i   = 1'b1;
    ex_target_i = 32'hDEAD_BEEF;
    sample();
    chk_comb("rst", 1'b0, 1'b0, 4'b0000, 4'b1111);
    chk("rst_target", 64'(pc_target_a), 64'h0);
    chk("rst_err", 64'(mem_err_a), 64'h0);
    chk("rst_cnt_a", 64'(cnt_a), 64'h0);
    adv();

    rst_i = 1'b0;
    idle();
    sample();
    chk_comb("idle", 1'b0, 1'b0, 4'b0000, 4'b0000);
    chk("idle_cnt_a", 64'(cnt_a), 64'h0);
    adv();

    // Taken BEQ to 0x100
    ex_jump_i   = 1'b1;
    ex_target_i = 32'h0000_0100;
    sample();
    chk_comb("beq", 1'b0, 1'b1, 4'b0000, 4'b0011);
    chk("beq_target", 64'(pc_target_a), 64'h100);
    chk("beq_cnt_before", 64'(cnt_a), 64'h0);
    adv();
    idle();
    sample();
    chk_comb("beq_redir", 1'b0, 1'b0, 4'b0000, 4'b0001);
    chk("beq_cnt_a", 64'(cnt_a), 64'h1);
    chk("beq_cnt_s", 64'(cnt_s), 64'h1);
    adv();
    sample();
    chk_comb("beq_clear", 1'b0, 1'b0, 4'b0000, 4'b0000);
    adv();

    // LW x5 in EX, ADD x6,x5,x1 in ID
    ex_is_load_i = 1'b1;
    ex_rd_i      = 5'd5;
    id_rs1_i     = 5'd5;
    id_rs2_i     = 5'd1;
    id_use_i     = 2'b11;
    sample();
    chk_comb("ldu_rs1", 1'b1, 1'b0, 4'b0001, 4'b0010);
    adv();
    // Match only on rs2, rs2 marked unused
    id_rs1_i = 5'd1;
    id_rs2_i = 5'd5;
    id_use_i = 2'b01;
    sample();
    chk_comb("ldu_unused", 1'b0, 1'b0, 4'b0000, 4'b0000);
    adv();
    // Match on rs2, rs2 used
    id_use_i = 2'b10;
    sample();
    chk_comb("ldu_rs2", 1'b1, 1'b0, 4'b0001, 4'b0010);
    adv();
    // Destination x0 never interlocks
    ex_rd_i  = 5'd0;
    id_rs1_i = 5'd0;
    id_rs2_i = 5'd0;
    id_use_i = 2'b11;
    sample();
    chk_comb("ldu_x0", 1'b0, 1'b0, 4'b0000, 4'b0000);
    adv();
    idle();

    // Memory access acked after 3 stalled cycles
    mem_req_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample();
      chk_comb($sformatf("mw3_c%0d", i), 1'b1, 1'b0, 4'b0111, 4'b1000);
      adv();
    end
    mem_ack_i = 1'b1;
    sample();
    chk_comb("mw3_ack", 1'b0, 1'b0, 4'b0000, 4'b0000);
    adv();
    idle();
    sample();
    chk_comb("mw3_after", 1'b0, 1'b0, 4'b0000, 4'b0000);
    chk("mw3_err_a", 64'(mem_err_a), 64'h0);
    chk("mw3_err_s", 64'(mem_err_s), 64'h0);
    adv();

    // Jump held across a 2-cycle memory wait
    mem_req_i   = 1'b1;
    ex_jump_i   = 1'b1;
    ex_target_i = 32'h0000_0200;
    for (int i = 0; i < 2; i++) begin
      sample();
      chk_comb($sformatf("jw_c%0d", i), 1'b1, 1'b0, 4'b0111, 4'b1000);
      adv();
    end
    mem_ack_i = 1'b1;
    sample();
    chk_comb("jw_ack", 1'b0, 1'b1, 4'b0000, 4'b0011);
    chk("jw_target", 64'(pc_target_a), 64'h200);
    adv();
    idle();
    sample();
    chk_comb("jw_redir", 1'b0, 1'b0, 4'b0000, 4'b0001);
    chk("jw_cnt_a", 64'(cnt_a), 64'h2);
    chk("jw_cnt_s", 64'(cnt_s), 64'h2);
    adv();
    sample();
    chk_comb("jw_clear", 1'b0, 1'b0, 4'b0000, 4'b0000);
    chk("jw_cnt_hold", 64'(cnt_a), 64'h2);
    adv();

    // No ack: the small instance times out after its 4th stalled cycle
    mem_req_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sample();
      chk_comb($sformatf("to_c%0d", i), 1'b1, 1'b0, 4'b0111, 4'b1000);
      chk($sformatf("to_err_s_c%0d", i), 64'(mem_err_s), 64'h0);
      adv();
    end
    mem_req_i = 1'b0;
    sample();
    chk("to_pulse_s", 64'(mem_err_s), 64'h1);
    chk("to_err_a", 64'(mem_err_a), 64'h0);
    chk("to_run_stall_s", 64'(stall_s), 64'h0);
    chk("to_wait_stall_a", 64'(stall_a), 64'h7);
    adv();
    mem_ack_i = 1'b1;
    sample();
    chk("to_pulse_end_s", 64'(mem_err_s), 64'h0);
    chk("to_ack_stall_a", 64'(stall_a), 64'h0);
    chk("to_ack_stall_s", 64'(stall_s), 64'h0);
    adv();
    idle();
    sample();
    chk_comb("to_after", 1'b0, 1'b0, 4'b0000, 4'b0000);
    adv();

    // Jump held for 10 cycles: jumps in REDIR are ignored, so 5 redirects
    ex_jump_i   = 1'b1;
    ex_target_i = 32'h0000_0400;
    for (int i = 0; i < 10; i++) begin
      sample();
      if (i % 2 == 0) begin
        chk_comb($sformatf("sat_c%0d", i), 1'b0, 1'b1, 4'b0000, 4'b0011);
      end else begin
        chk_comb($sformatf("sat_c%0d", i), 1'b0, 1'b0, 4'b0000, 4'b0001);
      end
      adv();
    end
    idle();
    sample();
    chk("sat_cnt_a", 64'(cnt_a), 64'h7);
    chk("sat_cnt_s", 64'(cnt_s), 64'h3);
    chk_comb("sat_clear", 1'b0, 1'b0, 4'b0000, 4'b0000);
    adv();

    // Reset in the middle of REDIR
    ex_jump_i   = 1'b1;
    ex_target_i = 32'h0000_0800;
    adv();
    idle();
    rst_i = 1'b1;
    sample();
    chk_comb("rstr", 1'b0, 1'b0, 4'b0000, 4'b1111);
    adv();
    rst_i = 1'b0;
    sample();
    chk_comb("rstr_run", 1'b0, 1'b0, 4'b0000, 4'b0000);
    chk("rstr_cnt_a", 64'(cnt_a), 64'h0);
    chk("rstr_cnt_s", 64'(cnt_s), 64'h0);
    adv();

    // Reset in the middle of MEM_WAIT: no error pulse afterwards
    mem_req_i = 1'b1;
    adv();
    adv();
    mem_req_i = 1'b0;
    rst_i     = 1'b1;
    sample();
    chk_comb("rstm", 1'b0, 1'b0, 4'b0000, 4'b1111);
    adv();
    rst_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sample();
      chk_comb($sformatf("rstm_run_c%0d", i), 1'b0, 1'b0, 4'b0000, 4'b0000);
      chk($sformatf("rstm_err_s_c%0d", i), 64'(mem_err_s), 64'h0);
      adv();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
